// File: rtl/quad_gen.sv
// Quadrature encoder generator: turns a step command (edge count, direction,
// edge period) into A/B quadrature outputs and an optional index pulse.
// Build option: define QUAD_GEN_INDEX_EN to track position and drive the index
// output i; without it, i is tied low and no position counter is built.
module quad_gen #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned INDEX_EDGES = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             cmd_dir,
  input  logic [DIV_W-1:0] cmd_period,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [1:0]       q,
  output logic             i
);

  typedef enum logic {IDLE, RUN} state_e;

`ifdef QUAD_GEN_INDEX_EN
  localparam int unsigned     POS_W   = (INDEX_EDGES > 1) ? $clog2(INDEX_EDGES) : 1;
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(INDEX_EDGES - 1);
  logic [POS_W-1:0] pos_q, pos_d;
  logic             i_q, i_d;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic             dir_q, dir_d;
  logic [DIV_W-1:0] reload_q, reload_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] per_m1_c;
  logic [1:0]       q_q, q_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // One Gray step: forward 00->01->11->10->00, reverse walks the other way.
  function automatic logic [1:0] gray_step(input logic [1:0] cur, input logic fwd);
    logic [1:0] nxt;
    nxt = cur;
    case (cur)
      2'b00:   nxt = fwd ? 2'b01 : 2'b10;
      2'b01:   nxt = fwd ? 2'b11 : 2'b00;
      2'b11:   nxt = fwd ? 2'b10 : 2'b01;
      default: nxt = fwd ? 2'b00 : 2'b11;
    endcase
    return nxt;
  endfunction

  // Next-state, divider, step counter and output logic.
  always_comb begin
    state_d     = state_q;
    steps_d     = steps_q;
    dir_d       = dir_q;
    reload_d    = reload_q;
    div_d       = div_q;
    q_d         = q_q;
    cmd_ready_d = cmd_ready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    per_m1_c    = (cmd_period == '0) ? '0 : cmd_period - DIV_W'(1);
`ifdef QUAD_GEN_INDEX_EN
    pos_d       = pos_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          if (cmd_steps == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = RUN;
            steps_d     = cmd_steps;
            dir_d       = cmd_dir;
            reload_d    = per_m1_c;
            div_d       = per_m1_c;
            cmd_ready_d = 1'b0;
            busy_d      = 1'b1;
          end
        end
      end
      RUN: begin
        // Abort outranks a divider expiry in the same cycle.
        if (abort || (steps_q == '0)) begin
          state_d     = IDLE;
          cmd_ready_d = 1'b1;
          busy_d      = 1'b0;
          done_d      = 1'b1;
        end else if (div_q == '0) begin
          q_d     = gray_step(q_q, dir_q);
          steps_d = steps_q - CNT_W'(1);
          div_d   = reload_q;
`ifdef QUAD_GEN_INDEX_EN
          if (dir_q) begin
            pos_d = (pos_q == POS_MAX) ? '0 : pos_q + POS_W'(1);
          end else begin
            pos_d = (pos_q == '0) ? POS_MAX : pos_q - POS_W'(1);
          end
`endif
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef QUAD_GEN_INDEX_EN
    i_d = (pos_d == '0);
`endif
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      steps_q     <= '0;
      dir_q       <= 1'b0;
      reload_q    <= '0;
      div_q       <= '0;
      q_q         <= 2'b00;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      steps_q     <= steps_d;
      dir_q       <= dir_d;
      reload_q    <= reload_d;
      div_q       <= div_d;
      q_q         <= q_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef QUAD_GEN_INDEX_EN
  // Position and index registers; index is high exactly at position 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q <= '0;
      i_q   <= 1'b1;
    end else begin
      pos_q <= pos_d;
      i_q   <= i_d;
    end
  end

  assign i = i_q;
`else
  assign i = 1'b0;
`endif

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign q         = q_q;

endmodule

// File: tb/tb_quad_gen.sv
// Directed bench for quad_gen: Gray sequence and timing, reverse stepping,
// index behaviour, zero-step and zero-period commands, abort and reset.
module tb_quad_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_steps;
  logic        cmd_dir;
  logic [15:0] cmd_period;
  logic        abort;
  logic        busy;
  logic        done;
  logic [1:0]  q;
  logic        i;

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0] fwd_seq [8];
  logic [1:0] rev_seq [8];
  logic [1:0] prev;

  quad_gen #(.CNT_W(16), .DIV_W(16), .INDEX_EDGES(4096)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_steps  (cmd_steps),
    .cmd_dir    (cmd_dir),
    .cmd_period (cmd_period),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .q          (q),
    .i          (i)
  );

  always #5 clk = ~clk;

  // Expected index level for a given "position is zero" fact.
  function automatic logic exp_i(input logic at_zero);
`ifdef QUAD_GEN_INDEX_EN
    return at_zero;
`else
    return 1'b0 & at_zero;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [1:0] eq, input logic eb,
                           input logic ed, input logic ei);
    chk({tag, ".q"},     32'(q),         32'(eq));
    chk({tag, ".busy"},  32'(busy),      32'(eb));
    chk({tag, ".ready"}, 32'(cmd_ready), 32'(!eb));
    chk({tag, ".done"},  32'(done),      32'(ed));
    chk({tag, ".i"},     32'(i),         32'(ei));
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Offer a command for one cycle, then scramble the fields.
  task automatic send(input int steps, input logic dir, input int period);
    cmd_steps  = 16'(steps);
    cmd_dir    = dir;
    cmd_period = 16'(period);
    cmd_valid  = 1'b1;
    @(negedge clk);
    cmd_valid  = 1'b0;
    cmd_steps  = 16'($urandom);
    cmd_dir    = 1'($urandom);
    cmd_period = 16'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fwd_seq = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
    rev_seq = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
    rst = 1'b1; cmd_valid = 1'b0; cmd_steps = '0; cmd_dir = 1'b0;
    cmd_period = '0; abort = 1'b0;
    tick(2);
    chk_state("reset", 2'b00, 1'b0, 1'b0, exp_i(1'b1));
    rst = 1'b0;

    // Forward 8 edges, period 3.
    send(8, 1'b1, 3);
    chk_state("t1_start", 2'b00, 1'b1, 1'b0, exp_i(1'b1));
    prev = 2'b00;
    for (int k = 0; k < 8; k++) begin
      tick(2);
      chk("t1_hold", 32'(q), 32'(prev));
      tick(1);
      chk("t1_edge", 32'(q), 32'(fwd_seq[k]));
      chk("t1_nodone", 32'(done), 32'd0);
      prev = fwd_seq[k];
    end
    tick(1);
    chk_state("t1_done", 2'b00, 1'b0, 1'b1, exp_i(1'b0));
    tick(1);
    chk_state("t1_idle", 2'b00, 1'b0, 1'b0, exp_i(1'b0));

    // Reverse 8 edges from position 0 down to 4088.
    rst = 1'b1; tick(1); rst = 1'b0;
    chk_state("t2_rst", 2'b00, 1'b0, 1'b0, exp_i(1'b1));
    send(8, 1'b0, 3);
    prev = 2'b00;
    for (int k = 0; k < 8; k++) begin
      tick(2);
      chk("t2_hold", 32'(q), 32'(prev));
      tick(1);
      chk("t2_edge", 32'(q), 32'(rev_seq[k]));
      chk("t2_i", 32'(i), 32'(exp_i(1'b0)));
      prev = rev_seq[k];
    end
    tick(1);
    chk_state("t2_done", 2'b00, 1'b0, 1'b1, exp_i(1'b0));
    tick(1);

    // Index: full revolution plus four, period 1.
    rst = 1'b1; tick(1); rst = 1'b0;
    send(4100, 1'b1, 1);
    chk_state("t3_start", 2'b00, 1'b1, 1'b0, exp_i(1'b1));
    tick(1);
    chk_state("t3_e1", 2'b01, 1'b1, 1'b0, exp_i(1'b0));
    tick(4094);
    chk_state("t3_e4095", 2'b10, 1'b1, 1'b0, exp_i(1'b0));
    tick(1);
    chk_state("t3_e4096", 2'b00, 1'b1, 1'b0, exp_i(1'b1));
    tick(1);
    chk_state("t3_e4097", 2'b01, 1'b1, 1'b0, exp_i(1'b0));
    tick(3);
    chk_state("t3_e4100", 2'b00, 1'b1, 1'b0, exp_i(1'b0));
    tick(1);
    chk_state("t3_done", 2'b00, 1'b0, 1'b1, exp_i(1'b0));
    send(4, 1'b0, 1);
    tick(3);
    chk_state("t3_rev3", 2'b01, 1'b1, 1'b0, exp_i(1'b0));
    tick(1);
    chk_state("t3_rev4", 2'b00, 1'b1, 1'b0, exp_i(1'b1));
    tick(1);
    chk_state("t3_rdone", 2'b00, 1'b0, 1'b1, exp_i(1'b1));
    send(1, 1'b0, 1);
    tick(1);
    chk_state("t3_wrap", 2'b10, 1'b1, 1'b0, exp_i(1'b0));
    tick(1);
    send(1, 1'b1, 1);
    tick(1);
    chk_state("t3_back", 2'b00, 1'b1, 1'b0, exp_i(1'b1));
    tick(1);

    // Zero steps, then zero period.
    send(0, 1'b1, 5);
    chk_state("t4_zero", 2'b00, 1'b0, 1'b1, exp_i(1'b1));
    tick(1);
    chk_state("t4_zidle", 2'b00, 1'b0, 1'b0, exp_i(1'b1));
    send(2, 1'b1, 0);
    chk_state("t4_p0s", 2'b00, 1'b1, 1'b0, exp_i(1'b1));
    tick(1);
    chk_state("t4_p0e1", 2'b01, 1'b1, 1'b0, exp_i(1'b0));
    tick(1);
    chk_state("t4_p0e2", 2'b11, 1'b1, 1'b0, exp_i(1'b0));
    tick(1);
    chk_state("t4_done", 2'b11, 1'b0, 1'b1, exp_i(1'b0));

    // Accepted in the done cycle; abort two cycles after edge 3.
    send(10, 1'b1, 4);
    chk_state("t5_start", 2'b11, 1'b1, 1'b0, exp_i(1'b0));
    tick(4);  chk("t5_e1", 32'(q), 32'(2'b10));
    tick(4);  chk("t5_e2", 32'(q), 32'(2'b00));
    tick(4);  chk("t5_e3", 32'(q), 32'(2'b01));
    tick(2);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk_state("t5_abort", 2'b01, 1'b0, 1'b1, exp_i(1'b0));
    tick(1);
    chk_state("t5_after", 2'b01, 1'b0, 1'b0, exp_i(1'b0));
    tick(3);
    chk("t5_hold", 32'(q), 32'(2'b01));

    // Abort on the same cycle the divider expires.
    send(3, 1'b1, 2);
    tick(1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk_state("t5_coinc", 2'b01, 1'b0, 1'b1, exp_i(1'b0));
    tick(1);
    chk_state("t5_cidle", 2'b01, 1'b0, 1'b0, exp_i(1'b0));

    // Abort while idle is ignored.
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk_state("t5_idleab", 2'b01, 1'b0, 1'b0, exp_i(1'b0));

    // Reset in the middle of a run.
    send(8, 1'b1, 3);
    tick(3);
    chk("t6_e1", 32'(q), 32'(2'b11));
    tick(1);
    rst = 1'b1;
    tick(1);
    chk_state("t6_rst", 2'b00, 1'b0, 1'b0, exp_i(1'b1));
    rst = 1'b0;
    send(1, 1'b1, 1);
    tick(1);
    chk_state("t6_e1b", 2'b01, 1'b1, 1'b0, exp_i(1'b0));
    tick(1);
    chk_state("t6_done", 2'b01, 1'b0, 1'b1, exp_i(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
